cve2_mult_arbiter: RTL and testbench

Shares the single core multiplier between two requesters: port 0 = EX-stage MUL instructions, port 1 = MAC sequencer multiply phase. Registered arbitration picks one owner. It latches that owner's operands and drives the multiplier until it reports completion. It then returns a one-cycle result pulse to the owner. The block sits between the ID/EX operand muxing and the multiplier's enable/operand inputs.

---
 rtl/cve2_mult_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_cve2_mult_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_mult_arbiter.sv
// Arbitrates the shared core multiplier between the EX-stage MUL path (port 0)
// and the MAC sequencer (port 1); one owner drives the multiplier until completion.
module cve2_mult_arbiter #(
  parameter int unsigned Width       = 32,
  parameter bit          RoundRobin  = 1'b1,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           req_i,
  input  logic [2*Width-1:0]   op_a_i,
  input  logic [2*Width-1:0]   op_b_i,
  input  logic [3:0]           md_op_i,
  input  logic [3:0]           signed_mode_i,
  input  logic [1:0]           flush_i,
  output logic [1:0]           gnt_o,
  output logic [1:0]           rvalid_o,
  output logic [Width-1:0]     result_o,
  output logic                 busy_o,
  output logic                 mul_en_o,
  output logic [Width-1:0]     mul_op_a_o,
  output logic [Width-1:0]     mul_op_b_o,
  output logic [1:0]           mul_md_op_o,
  output logic [1:0]           mul_signed_mode_o,
  input  logic                 mul_valid_i,
  input  logic [Width-1:0]     mul_result_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  state_e            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_owner_reg, last_owner_next;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        rvalid_reg, rvalid_next;
  logic [Width-1:0]  result_reg, result_next;
  logic              mul_en_reg, mul_en_next;
  logic [Width-1:0]  op_a_reg, op_a_next;
  logic [Width-1:0]  op_b_reg, op_b_next;
  logic [1:0]        md_op_reg, md_op_next;
  logic [1:0]        signed_mode_reg, signed_mode_next;

  logic [Width-1:0]  port_a [2];
  logic [Width-1:0]  port_b [2];
  logic [1:0]        port_md [2];
  logic [1:0]        port_sm [2];

  logic [1:0]        eligible;
  logic              tie;
  logic              winner;
  logic              aborted;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign port_a[gi]  = op_a_i[gi*Width +: Width];
    assign port_b[gi]  = op_b_i[gi*Width +: Width];
    assign port_md[gi] = md_op_i[gi*2 +: 2];
    assign port_sm[gi] = signed_mode_i[gi*2 +: 2];
  end

  assign eligible = req_i & ~flush_i;
  assign tie      = &eligible;
  assign aborted  = flush_i[owner_reg] | ~req_i[owner_reg];

  always_comb begin
    winner = eligible[1];
    if (tie) begin
      if (RoundRobin) begin
        winner = ~last_owner_reg;
      end else begin
        winner = (starve_cnt_reg == StarveMax);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_owner_next  = last_owner_reg;
    starve_cnt_next  = starve_cnt_reg;
    gnt_next         = gnt_reg;
    rvalid_next      = '0;
    result_next      = result_reg;
    mul_en_next      = mul_en_reg;
    op_a_next        = op_a_reg;
    op_b_next        = op_b_reg;
    md_op_next       = md_op_reg;
    signed_mode_next = signed_mode_reg;

    unique case (state_reg)
      IDLE: begin
        if (|eligible) begin
          state_next       = BUSY;
          owner_next       = winner;
          last_owner_next  = winner;
          gnt_next         = winner ? 2'b10 : 2'b01;
          mul_en_next      = 1'b1;
          op_a_next        = port_a[winner];
          op_b_next        = port_b[winner];
          md_op_next       = port_md[winner];
          signed_mode_next = port_sm[winner];
          // Only contested wins by port 0 count toward starving port 1.
          if (winner) begin
            starve_cnt_next = '0;
          end else if (tie && (starve_cnt_reg != StarveMax)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
          end
        end
      end
      BUSY: begin
        if (aborted) begin
          state_next  = IDLE;
          mul_en_next = 1'b0;
          gnt_next    = '0;
        end else if (mul_valid_i) begin
          state_next  = DONE;
          mul_en_next = 1'b0;
          result_next = mul_result_i;
          rvalid_next = owner_reg ? 2'b10 : 2'b01;
        end
      end
      DONE: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
      default: begin
        state_next  = IDLE;
        gnt_next    = '0;
        mul_en_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_owner_reg  <= 1'b1;
      starve_cnt_reg  <= '0;
      gnt_reg         <= '0;
      rvalid_reg      <= '0;
      result_reg      <= '0;
      mul_en_reg      <= 1'b0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      md_op_reg       <= '0;
      signed_mode_reg <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_owner_reg  <= last_owner_next;
      starve_cnt_reg  <= starve_cnt_next;
      gnt_reg         <= gnt_next;
      rvalid_reg      <= rvalid_next;
      result_reg      <= result_next;
      mul_en_reg      <= mul_en_next;
      op_a_reg        <= op_a_next;
      op_b_reg        <= op_b_next;
      md_op_reg       <= md_op_next;
      signed_mode_reg <= signed_mode_next;
    end
  end

  assign gnt_o             = gnt_reg;
  assign rvalid_o          = rvalid_reg;
  assign result_o          = result_reg;
  assign busy_o            = (state_reg != IDLE);
  assign mul_en_o          = mul_en_reg;
  assign mul_op_a_o        = op_a_reg;
  assign mul_op_b_o        = op_b_reg;
  assign mul_md_op_o       = md_op_reg;
  assign mul_signed_mode_o = signed_mode_reg;

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));
  a_rvalid_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   ((rvalid_o & ~gnt_o) == 2'b00));
  a_en_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
                              mul_en_o |-> (state_reg == BUSY));
`endif

endmodule

// File: tb/tb_cve2_mult_arbiter.sv
// Bench for cve2_mult_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each with a behavioural multiplier of programmable latency.
module tb_cve2_mult_arbiter;

  localparam logic [1:0] MULL = 2'b00;
  localparam logic [1:0] MULH = 2'b01;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req [2];
  logic [1:0]  flush [2];
  logic [63:0] op_a [2];
  logic [63:0] op_b [2];
  logic [3:0]  md [2];
  logic [3:0]  sm [2];
  logic [1:0]  gnt [2];
  logic [1:0]  rvalid [2];
  logic [31:0] result [2];
  logic        busy [2];
  logic        mul_en [2];
  logic [31:0] mul_a [2];
  logic [31:0] mul_b [2];
  logic [1:0]  mul_md [2];
  logic [1:0]  mul_sm [2];
  logic        mul_valid [2];
  logic [31:0] mul_res [2];
  int          lat [2];
  int          cnt [2];

  int          checks;
  int          failures;
  int          exp_gnt_q [$];
  int          exp_tag_q [$];
  logic [31:0] exp_val_q [$];
  logic [1:0]  prev_gnt [2];
  int          mon_tag;
  logic [31:0] mon_val;

  logic [31:0] sa [2][8];
  logic [31:0] sb [2][8];

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] mdv, input logic [1:0] smv);
    logic [63:0] ea, eb, pr;
    ea = smv[0] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = smv[1] ? {{32{b[31]}}, b} : {32'b0, b};
    pr = ea * eb;
    return (mdv == MULH) ? pr[63:32] : pr[31:0];
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    cve2_mult_arbiter #(
      .Width(32),
      .RoundRobin(gi == 0),
      .StarveLimit(4)
    ) u_dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .req_i(req[gi]),
      .op_a_i(op_a[gi]),
      .op_b_i(op_b[gi]),
      .md_op_i(md[gi]),
      .signed_mode_i(sm[gi]),
      .flush_i(flush[gi]),
      .gnt_o(gnt[gi]),
      .rvalid_o(rvalid[gi]),
      .result_o(result[gi]),
      .busy_o(busy[gi]),
      .mul_en_o(mul_en[gi]),
      .mul_op_a_o(mul_a[gi]),
      .mul_op_b_o(mul_b[gi]),
      .mul_md_op_o(mul_md[gi]),
      .mul_signed_mode_o(mul_sm[gi]),
      .mul_valid_i(mul_valid[gi]),
      .mul_result_i(mul_res[gi])
    );
    assign mul_valid[gi] = mul_en[gi] && (cnt[gi] == lat[gi] - 1);
    assign mul_res[gi]   = mul_model(mul_a[gi], mul_b[gi], mul_md[gi], mul_sm[gi]);
    always @(posedge clk) cnt[gi] <= mul_en[gi] ? cnt[gi] + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: new grants and result pulses are matched against the queues.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (gnt[d] != 2'b00 && prev_gnt[d] == 2'b00) begin
        if (exp_gnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL gnt_unexpected dut=%0d actual=%b required=none", d, gnt[d]);
        end else begin
          mon_tag = exp_gnt_q.pop_front();
          chk("gnt_owner", 32'(d * 4 + int'(gnt[d])), 32'(mon_tag));
        end
      end
      if (rvalid[d] != 2'b00) begin
        if (exp_tag_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rvalid_unexpected dut=%0d actual=%b required=none", d, rvalid[d]);
        end else begin
          mon_tag = exp_tag_q.pop_front();
          mon_val = exp_val_q.pop_front();
          chk("rvalid_owner", 32'(d * 4 + int'(rvalid[d])), 32'(mon_tag));
          chk("result", result[d], mon_val);
        end
      end
      prev_gnt[d] <= gnt[d];
    end
  end

  task automatic push_gnt(input int d, input int p);
    exp_gnt_q.push_back(d * 4 + (1 << p));
  endtask

  task automatic push_res(input int d, input int p, input logic [31:0] v);
    exp_tag_q.push_back(d * 4 + (1 << p));
    exp_val_q.push_back(v);
  endtask

  task automatic drive_op(input int d, input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] mdv, input logic [1:0] smv);
    op_a[d][p*32 +: 32] = a;
    op_b[d][p*32 +: 32] = b;
    md[d][p*2 +: 2]     = mdv;
    sm[d][p*2 +: 2]     = smv;
    req[d][p]           = 1'b1;
  endtask

  task automatic check_zero(input int d);
    chk("rst_gnt", 32'(gnt[d]), 32'd0);
    chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
    chk("rst_result", result[d], 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_mul_en", 32'(mul_en[d]), 32'd0);
    chk("rst_mul_a", mul_a[d], 32'd0);
    chk("rst_mul_b", mul_b[d], 32'd0);
    chk("rst_mul_md", 32'(mul_md[d]), 32'd0);
    chk("rst_mul_sm", 32'(mul_sm[d]), 32'd0);
  endtask

  // One isolated operation with cycle-exact checks; cycle 0 is the request cycle.
  task automatic single_op(input int d, input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] mdv, input logic [1:0] smv, input int l,
                           input logic [31:0] expv);
    lat[d] = l;
    @(posedge clk);
    #1;
    drive_op(d, p, a, b, mdv, smv);
    push_gnt(d, p);
    push_res(d, p, expv);
    @(negedge clk);
    @(negedge clk);
    chk("gnt_cycle1", 32'(gnt[d]), 32'(1 << p));
    chk("busy_cycle1", 32'(busy[d]), 32'd1);
    for (int i = 0; i < l; i++) begin
      if (i > 0) @(negedge clk);
      chk("mul_en_held", 32'(mul_en[d]), 32'd1);
      chk("mul_a_held", mul_a[d], a);
      chk("mul_b_held", mul_b[d], b);
      chk("mul_md_held", 32'(mul_md[d]), 32'(mdv));
      chk("mul_sm_held", 32'(mul_sm[d]), 32'(smv));
      chk("rvalid_early", 32'(rvalid[d]), 32'd0);
    end
    @(negedge clk);
    chk("rvalid_latency", 32'(rvalid[d]), 32'(1 << p));
    chk("mul_en_done", 32'(mul_en[d]), 32'd0);
    req[d][p] = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(busy[d]), 32'd0);
    chk("gnt_after", 32'(gnt[d]), 32'd0);
  endtask

  task automatic load(input int d, input int p, input int k);
    drive_op(d, p, sa[p][k], sb[p][k], MULL, 2'b00);
  endtask

  // Both ports keep requesting; each advances to its next operand set on its own rvalid.
  task automatic run_stream(input int d, input int n0, input int n1);
    int idx [2];
    int n [2];
    n[0] = n0;
    n[1] = n1;
    idx[0] = 0;
    idx[1] = 0;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) if (n[p] > 0) load(d, p, 0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (rvalid[d][p]) begin
          idx[p]++;
          if (idx[p] < n[p]) load(d, p, idx[p]);
          else req[d][p] = 1'b0;
        end
      end
      if (idx[0] >= n0 && idx[1] >= n1) break;
    end
    chk("stream_ops_done", 32'(idx[0] + idx[1]), 32'(n0 + n1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; flush[d] = '0; op_a[d] = '0; op_b[d] = '0;
      md[d] = '0; sm[d] = '0; lat[d] = 1;
    end
    #12;
    check_zero(0);
    check_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    single_op(0, 0, 32'd7, 32'd6, MULL, 2'b00, 1, 32'd42);
    single_op(0, 1, 32'hFFFF_FFFD, 32'd5, MULL, 2'b11, 4, 32'hFFFF_FFF1);
    single_op(0, 0, 32'h8000_0000, 32'd4, MULH, 2'b00, 2, 32'd2);
    single_op(0, 1, 32'hFFFF_FFFD, 32'd5, MULH, 2'b11, 1, 32'hFFFF_FFFF);

    // Round-robin: last owner is port 1, so port 0 takes the first tie.
    lat[0] = 1;
    sa[0] = '{32'd5, 32'd9, 32'd100, 32'd12, 0, 0, 0, 0};
    sb[0] = '{32'd3, 32'd4, 32'd7, 32'd11, 0, 0, 0, 0};
    sa[1] = '{32'd2, 32'd6, 32'd13, 32'd1000, 0, 0, 0, 0};
    sb[1] = '{32'd8, 32'd9, 32'd3, 32'd1000, 0, 0, 0, 0};
    push_gnt(0, 0); push_res(0, 0, 32'd15);
    push_gnt(0, 1); push_res(0, 1, 32'd16);
    push_gnt(0, 0); push_res(0, 0, 32'd36);
    push_gnt(0, 1); push_res(0, 1, 32'd54);
    push_gnt(0, 0); push_res(0, 0, 32'd700);
    push_gnt(0, 1); push_res(0, 1, 32'd39);
    push_gnt(0, 0); push_res(0, 0, 32'd132);
    push_gnt(0, 1); push_res(0, 1, 32'd1000000);
    run_stream(0, 4, 4);

    // Fixed priority: port 0 wins four ties, then port 1 is forced through.
    lat[1] = 1;
    sa[0] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    sb[0] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
    sa[1] = '{32'd20, 32'd30, 0, 0, 0, 0, 0, 0};
    sb[1] = '{32'd5, 32'd7, 0, 0, 0, 0, 0, 0};
    push_gnt(1, 0); push_res(1, 0, 32'd3);
    push_gnt(1, 0); push_res(1, 0, 32'd6);
    push_gnt(1, 0); push_res(1, 0, 32'd9);
    push_gnt(1, 0); push_res(1, 0, 32'd12);
    push_gnt(1, 1); push_res(1, 1, 32'd100);
    push_gnt(1, 0); push_res(1, 0, 32'd15);
    push_gnt(1, 0); push_res(1, 0, 32'd18);
    push_gnt(1, 0); push_res(1, 0, 32'd21);
    push_gnt(1, 0); push_res(1, 0, 32'd24);
    push_gnt(1, 1); push_res(1, 1, 32'd210);
    run_stream(1, 8, 2);

    // Flush of the owner in the same cycle as mul_valid: abort wins, port 1 follows.
    lat[0] = 2;
    @(posedge clk);
    #1;
    drive_op(0, 0, 32'd3, 32'd3, MULL, 2'b00);
    drive_op(0, 1, 32'd11, 32'd11, MULL, 2'b00);
    push_gnt(0, 0);
    push_gnt(0, 1);
    push_res(0, 1, 32'd121);
    @(negedge clk);
    @(negedge clk);
    chk("flush_gnt_c1", 32'(gnt[0]), 32'b01);
    @(posedge clk);
    #1;
    flush[0][0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("flush_mul_en", 32'(mul_en[0]), 32'd0);
    chk("flush_gnt", 32'(gnt[0]), 32'd0);
    chk("flush_rvalid", 32'(rvalid[0]), 32'd0);
    chk("flush_busy", 32'(busy[0]), 32'd0);
    chk("flush_result_kept", result[0], 32'd1000000);
    flush[0][0] = 1'b0;
    req[0][0]   = 1'b0;
    @(negedge clk);
    chk("flush_next_gnt", 32'(gnt[0]), 32'b10);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (rvalid[0][1]) seen = 1'b1;
      end
      req[0][1] = 1'b0;
      chk("flush_port1_done", 32'(seen), 32'd1);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a long operation.
    lat[0] = 10;
    @(posedge clk);
    #1;
    drive_op(0, 0, 32'd9, 32'd9, MULL, 2'b00);
    push_gnt(0, 0);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(0);
    req[0][0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lat[0] = 1;
    sa[0] = '{32'd4, 0, 0, 0, 0, 0, 0, 0};
    sb[0] = '{32'd5, 0, 0, 0, 0, 0, 0, 0};
    sa[1] = '{32'd6, 0, 0, 0, 0, 0, 0, 0};
    sb[1] = '{32'd7, 0, 0, 0, 0, 0, 0, 0};
    push_gnt(0, 0); push_res(0, 0, 32'd20);
    push_gnt(0, 1); push_res(0, 1, 32'd42);
    run_stream(0, 1, 1);

    repeat (3) @(negedge clk);
    chk("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
    chk("result_queue_empty", 32'(exp_tag_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
